// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered stream mux with explicit-select or round-robin grant
module stream_mux_rr #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic            can_load;
    logic            grant_vld;
    logic [SELW-1:0] grant;
    logic [SELW-1:0] ptr;
    logic [WIDTH-1:0] grant_data;
    logic            xfer;

    // Output slot is free when empty or being drained this cycle.
    assign can_load = !out_valid || out_ready;

    // Round-robin search is split into two passes: channels at/after ptr, then wrapped ones.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (!mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant     = SELW'(i);
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!grant_vld && in_valid[i] && SELW'(i) >= ptr) begin
                    grant_vld = 1'b1;
                    grant     = SELW'(i);
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (!grant_vld && in_valid[i] && SELW'(i) < ptr) begin
                    grant_vld = 1'b1;
                    grant     = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == SELW'(i)) begin
                in_ready[i] = rst_n && can_load && grant_vld;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = rst_n && can_load && grant_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant;
            ptr       <= (grant == SELW'(NCH-1)) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed bench for stream_mux_rr (4-channel and 3-channel instances)
module tb_stream_mux_rr;

    logic         clk;
    logic         rst_n;

    logic         mode4, out_ready4, out_valid4;
    logic [1:0]   sel4, out_ch4;
    logic [127:0] in_data4;
    logic [3:0]   in_valid4, in_ready4;
    logic [31:0]  out_data4;

    logic         mode3, out_ready3, out_valid3;
    logic [1:0]   sel3, out_ch3;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3, in_ready3;
    logic [31:0]  out_data3;

    int errors = 0;
    int checks = 0;

    stream_mux_rr #(.WIDTH(32), .NCH(4), .SELW(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_ch(out_ch4), .out_valid(out_valid4),
        .out_ready(out_ready4)
    );

    stream_mux_rr #(.WIDTH(32), .NCH(3), .SELW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n      = 1'b0;
        mode4      = 1'b1;
        sel4       = 2'd0;
        in_valid4  = 4'b1111;
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'hA0 + i;
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'hB0 + i;
        #1;
        chk("reset_out_valid", out_valid4, 0);
        chk("reset_out_data", out_data4, 0);
        chk("reset_out_ch", out_ch4, 0);
        chk("reset_in_ready", in_ready4, 4'b0000);

        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rr_first_ready", in_ready4, 4'b0001);

        // Round-robin over all four channels, no bubbles.
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr4_out_ch", out_ch4, k % 4);
            chk("rr4_out_valid", out_valid4, 1);
            chk("rr4_out_data", out_data4, 32'hA0 + (k % 4));
        end

        in_valid4 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr2_out_ch", out_ch4, (k % 2 == 0) ? 1 : 3);
        end

        // Reset mid-stream with a word held.
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid4, 0);
        chk("midrst_out_data", out_data4, 0);
        chk("midrst_out_ch", out_ch4, 0);
        chk("midrst_in_ready", in_ready4, 4'b0000);
        rst_n     = 1'b1;
        in_valid4 = 4'b1111;
        #1;
        chk("postrst_ready", in_ready4, 4'b0001);
        step();
        chk("postrst_out_ch", out_ch4, 0);

        // Explicit select of channel 2.
        mode4 = 1'b0;
        sel4  = 2'd2;
        #1;
        chk("sel2_in_ready", in_ready4, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("sel2_out_data", out_data4, 32'hA2);
            chk("sel2_out_ch", out_ch4, 2);
        end

        // Backpressure: hold a channel-1 word, ptr left at 2.
        sel4 = 2'd1;
        step();
        chk("bp_load_ch", out_ch4, 1);
        mode4      = 1'b1;
        out_ready4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", in_ready4, 4'b0000);
            step();
            chk("bp_out_data", out_data4, 32'hA1);
            chk("bp_out_ch", out_ch4, 1);
            chk("bp_out_valid", out_valid4, 1);
        end
        out_ready4 = 1'b1;
        #1;
        chk("bp_release_ready", in_ready4, 4'b0100);
        step();
        chk("bp_next_ch", out_ch4, 2);
        chk("bp_next_valid", out_valid4, 1);

        // Mode switch while a word is held.
        out_ready4 = 1'b0;
        step();
        mode4 = 1'b0;
        sel4  = 2'd0;
        step();
        chk("msw_held_ch", out_ch4, 2);
        chk("msw_held_data", out_data4, 32'hA2);
        out_ready4 = 1'b1;
        #1;
        chk("msw_ready", in_ready4, 4'b0001);
        step();
        chk("msw_next_ch", out_ch4, 0);
        chk("msw_next_data", out_data4, 32'hA0);

        // Selected channel not valid: no grant, output drains.
        in_valid4 = 4'b1110;
        #1;
        chk("selinv_ready", in_ready4, 4'b0000);
        step();
        chk("selinv_drain", out_valid4, 0);

        in_data4[3*32 +: 32] = 32'hDEADBEEF;
        in_valid4 = 4'b1000;
        sel4      = 2'd3;
        step();
        chk("sel3_data", out_data4, 32'hDEADBEEF);
        chk("sel3_ch", out_ch4, 3);

        // Three-channel instance: out-of-range select, idle, pointer wrap.
        in_valid3 = 3'b111;
        sel3      = 2'd2;
        #1;
        chk("n3_sel2_ready", in_ready3, 3'b100);
        step();
        chk("n3_sel2_valid", out_valid3, 1);
        chk("n3_sel2_ch", out_ch3, 2);
        sel3 = 2'd3;
        #1;
        chk("n3_oor_ready", in_ready3, 3'b000);
        step();
        chk("n3_oor_drain", out_valid3, 0);
        mode3     = 1'b1;
        in_valid3 = 3'b000;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("n3_idle_ready", in_ready3, 3'b000);
            step();
            chk("n3_idle_valid", out_valid3, 0);
        end
        in_valid3 = 3'b111;
        #1;
        chk("n3_wrap_ready", in_ready3, 3'b001);
        step();
        chk("n3_wrap_ch", out_ch3, 0);
        chk("n3_wrap_data", out_data3, 32'hB0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel, WIDTH-bit registered stream multiplexer for the pipelined datapath. It is the successor to the plain 2:1 combinational word select.
- Each input channel carries a valid/ready handshake.
- The block either follows an explicit select or arbitrates round-robin among requesters.
- One output register stage drives a downstream valid/ready consumer.
- Typical uses: merging writeback and memory-response sources, and sharing a port between several requesters.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- NCH, 4, number of input channels; NCH >= 2.
- SELW, 2, width of the select and channel-ID fields; 2**SELW >= NCH is required.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = explicit select, 1 = round-robin arbitration.
- sel  input  SELW  channel index used when mode=0.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- out_data  output  WIDTH  registered output word.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0. in_ready is all-zero while in reset.
- can_load = !out_valid || out_ready. This makes the block full-throughput: one word per cycle with no bubbles when out_ready stays high.
- Grant g is combinational:
  - mode=0: g=sel, but only if sel<NCH and in_valid[sel]=1; otherwise there is no grant.
  - mode=1: g is the first i with in_valid[i]=1, searching ptr, ptr+1, …, NCH-1, 0, …, ptr-1 (wrap-around). If no in_valid bit is set, there is no grant.
- in_ready[i] = can_load && (a grant exists) && (i == g). At most one in_ready bit is ever high.
- In mode 0, in_ready[sel] also depends on in_valid[sel]. Sources must not wait for ready before asserting valid.
- in_ready depends combinationally on out_ready; there is no skid buffer.
- Transfer = in_valid[g] && in_ready[g]. On a transfer, at the next edge:
  - out_data <= channel g's data.
  - out_ch <= g.
  - out_valid <= 1.
  - ptr <= (g == NCH-1) ? 0 : g+1.
  - ptr updates in both modes.
- No transfer and out_ready=1: out_valid <= 0. out_data and out_ch hold their values, which are don't-care.
- Backpressure (out_valid=1, out_ready=0): out_data, out_ch and out_valid stay stable, and all in_ready bits are 0.
- Simultaneous events:
  - Output consumed and new transfer in the same cycle: the new word replaces the old one and out_valid stays 1.
  - A change of mode or sel affects only the next grant; a word already held in the output register is never altered.
- sel >= NCH (mode=0): no grant, all in_ready=0, and no state changes except draining the output.
- Reset mid-operation: any held word is discarded immediately. The first grant after reset in mode 1 starts from channel 0.
- Latency: 1 cycle from input transfer to out_valid.

Test Plan:
1. Reset check: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 before the next edge; release reset, all four channels valid, mode=1 -> the first output has out_ch=0.
2. Explicit select: mode=0, sel=2, in_valid=4'b1111, data[i]=32'hA0+i, out_ready=1 -> in_ready=4'b0100; from cycle 1 on, out_data=32'hA2, out_ch=2 every cycle.
3. Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles. Then in_valid=4'b1010 -> out_ch alternates 1,3,1,3.
4. Backpressure: hold a word with out_ch=1, then out_ready=0 for 3 cycles -> out_data and out_ch are unchanged and in_ready=0. Raise out_ready -> the next granted channel is 2 (ptr was left at 2), and out_valid stays 1 throughout.
5. Out-of-range select and idle: NCH=3, SELW=2, mode=0, sel=3 -> in_ready=3'b000, and out_valid falls to 0 one cycle after being consumed. Then mode=1, in_valid=0 -> out_valid stays 0.
6. Mode switch with a held word: out_valid=1, out_ready=0, toggle mode 1->0 with sel=0 -> the held word is unchanged; after out_ready=1, the next word comes from channel 0.
